msrv32_dbus_ctrl: RTL and testbench

AHB-Lite master sequencer for the core's data port. It sits between the store unit / load path and the data bus. It captures one load or store request, then runs the address phase and the data phase. It absorbs wait states, reports bus errors and timeouts, and holds the pipeline stalled until the transfer retires. Transfers are single and non-pipelined; there is no overlap between consecutive transfers.

---
 rtl/msrv32_dbus_ctrl_if.sv | 25 ++
 rtl/msrv32_dbus_ctrl.sv | 141 ++++++++++++++
 tb/tb_msrv32_dbus_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_dbus_ctrl_if.sv
// AHB-Lite data-port signals between the core's bus sequencer (master)
// and the data-side slave.
interface msrv32_dbus_ctrl_if;
   logic [31:0] ahb_haddr_out;
   logic [1:0]  ahb_htrans_out;
   logic        ahb_hwrite_out;
   logic [2:0]  ahb_hsize_out;
   logic [31:0] ahb_hwdata_out;
   logic [3:0]  ahb_wstrb_out;
   logic        ahb_hready_in;
   logic        ahb_hresp_in;
   logic [31:0] ahb_hrdata_in;

   modport master (
      output ahb_haddr_out, ahb_htrans_out, ahb_hwrite_out, ahb_hsize_out,
             ahb_hwdata_out, ahb_wstrb_out,
      input  ahb_hready_in, ahb_hresp_in, ahb_hrdata_in
   );

   modport slave (
      input  ahb_haddr_out, ahb_htrans_out, ahb_hwrite_out, ahb_hsize_out,
             ahb_hwdata_out, ahb_wstrb_out,
      output ahb_hready_in, ahb_hresp_in, ahb_hrdata_in
   );
endinterface

// File: rtl/msrv32_dbus_ctrl.sv
// Single-transfer AHB-Lite sequencer for the core data port: captures one
// load/store, runs address and data phase, and stalls the pipe until it retires.
module msrv32_dbus_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   input  logic        wr_req_in,
   input  logic        rd_req_in,
   input  logic [31:0] d_addr_in,
   input  logic [31:0] wdata_in,
   input  logic [3:0]  wr_mask_in,
   input  logic [1:0]  funct3_in,
   output logic [31:0] rdata_out,
   output logic        stall_out,
   output logic        done_out,
   output logic        err_out,
   output logic        timeout_out,
   msrv32_dbus_ctrl_if.master ahb
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_e;

   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        tmo_q, tmo_d;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  mask_q;
   logic [2:0]  size_q;
   logic        hwrite_q;
   logic [31:0] rdata_q;

   logic        req;
   logic        data_ok;

   assign req     = wr_req_in | rd_req_in;
   assign data_ok = (state_q == S_DATA) & ahb.ahb_hready_in & ~ahb.ahb_hresp_in;

   // State register, wait-state counter and timeout classification
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            tmo_d = 1'b0;
            if (req) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (ahb.ahb_hready_in) begin
               state_d = S_DATA;
               cnt_d   = 8'd0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = S_ERR;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DATA: begin
            // An error response wins over hready and over a pending timeout
            if (ahb.ahb_hresp_in) begin
               state_d = S_ERR;
               tmo_d   = 1'b0;
            end else if (ahb.ahb_hready_in) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = S_ERR;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture and load-data register
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         mask_q   <= 4'd0;
         size_q   <= 3'd0;
         hwrite_q <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         if (state_q == S_IDLE && req) begin
            addr_q   <= d_addr_in;
            hwrite_q <= wr_req_in;
            // Reads carry no write data or strobes onto the bus
            wdata_q  <= wr_req_in ? wdata_in : 32'd0;
            mask_q   <= wr_req_in ? wr_mask_in : 4'd0;
            size_q   <= funct3_in[1] ? 3'b010 : {2'b00, funct3_in[0]};
         end
         if (data_ok && !hwrite_q) rdata_q <= ahb.ahb_hrdata_in;
      end
   end

   always_comb begin
      ahb.ahb_htrans_out = (state_q == S_ADDR) ? 2'b10 : 2'b00;
      ahb.ahb_haddr_out  = addr_q;
      ahb.ahb_hwrite_out = hwrite_q;
      ahb.ahb_hsize_out  = size_q;
      ahb.ahb_hwdata_out = (state_q == S_DATA) ? wdata_q : 32'd0;
      ahb.ahb_wstrb_out  = (state_q == S_DATA) ? mask_q : 4'd0;
      rdata_out          = rdata_q;
      done_out           = (state_q == S_DONE);
      err_out            = (state_q == S_ERR);
      timeout_out        = (state_q == S_ERR) & tmo_q;
      // Combinational so the pipe holds in the very cycle a request shows up
      stall_out          = (state_q == S_ADDR) | (state_q == S_DATA) |
                           ((state_q == S_IDLE) & req);
   end

endmodule

// File: tb/tb_msrv32_dbus_ctrl.sv
// Randomized bench for msrv32_dbus_ctrl: each transfer's cycle schedule and
// outcome are derived from its wait/error profile and compared every cycle.
module tb_msrv32_dbus_ctrl;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_req, rd_req;
   logic [31:0] d_addr, wdata;
   logic [3:0]  wr_mask;
   logic [1:0]  funct3;
   logic [31:0] rdata;
   logic        stall, done, err, tmo;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_rdata = 32'd0;

   always #5 clk = ~clk;

   msrv32_dbus_ctrl_if bus ();

   msrv32_dbus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .wr_req_in            (wr_req),
      .rd_req_in            (rd_req),
      .d_addr_in            (d_addr),
      .wdata_in             (wdata),
      .wr_mask_in           (wr_mask),
      .funct3_in            (funct3),
      .rdata_out            (rdata),
      .stall_out            (stall),
      .done_out             (done),
      .err_out              (err),
      .timeout_out          (tmo),
      .ahb                  (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".stall"},  32'(stall), 32'd0);
      chk({tag, ".done"},   32'(done),  32'd0);
      chk({tag, ".err"},    32'(err),   32'd0);
      chk({tag, ".htrans"}, 32'(bus.ahb_htrans_out), 32'd0);
      chk({tag, ".rdata"},  rdata, exp_rdata);
   endtask

   task automatic idle_cycle();
      wr_req = 1'b0;
      rd_req = 1'b0;
      bus.ahb_hready_in = 1'($urandom);
      bus.ahb_hresp_in  = 1'b0;
      bus.ahb_hrdata_in = $urandom;
      @(negedge clk);
      chk_quiet("idle");
      next_cycle();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".haddr"},  bus.ahb_haddr_out, 32'd0);
      chk({tag, ".hwrite"}, 32'(bus.ahb_hwrite_out), 32'd0);
      chk({tag, ".hsize"},  32'(bus.ahb_hsize_out), 32'd0);
      chk({tag, ".hwdata"}, bus.ahb_hwdata_out, 32'd0);
      chk({tag, ".wstrb"},  32'(bus.ahb_wstrb_out), 32'd0);
      chk({tag, ".tmo"},    32'(tmo), 32'd0);
      chk_quiet(tag);
   endtask

   // One transfer. wa/wdw: hready-low cycles in address/data phase;
   // err_at >= 0 puts hresp on that data-phase cycle (caller keeps it <= wdw).
   task automatic run_txn(input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] m,
                          input logic [1:0] fn, input int wa, input int wdw,
                          input int err_at, input logic [31:0] rdv);
      int          na, nd;
      bit          end_err, end_tmo, is_wr;
      logic [2:0]  sz;
      logic [31:0] cap;
      is_wr = w;
      sz    = (fn == 2'd0) ? 3'd0 : (fn == 2'd1) ? 3'd1 : 3'd2;
      cap   = exp_rdata;
      nd    = 0;
      if (wa >= TO) begin
         na = TO; end_err = 1; end_tmo = 1;
      end else begin
         na = wa + 1;
         if (err_at >= 0) begin
            nd = err_at + 1; end_err = 1; end_tmo = 0;
         end else if (wdw >= TO) begin
            nd = TO; end_err = 1; end_tmo = 1;
         end else begin
            nd = wdw + 1; end_err = 0; end_tmo = 0;
         end
      end

      wr_req = w; rd_req = r; d_addr = a; wdata = wd; wr_mask = m; funct3 = fn;
      bus.ahb_hready_in = 1'($urandom);
      bus.ahb_hresp_in  = 1'b0;
      bus.ahb_hrdata_in = $urandom;
      @(negedge clk);
      chk("req.stall",  32'(stall), 32'd1);
      chk("req.htrans", 32'(bus.ahb_htrans_out), 32'd0);
      chk("req.done",   32'(done), 32'd0);
      next_cycle();

      for (int k = 1; k <= na; k++) begin
         bus.ahb_hready_in = (k == na) && (wa < TO);
         bus.ahb_hresp_in  = 1'b0;
         bus.ahb_hrdata_in = $urandom;
         @(negedge clk);
         chk("addr.htrans", 32'(bus.ahb_htrans_out), 32'h2);
         chk("addr.haddr",  bus.ahb_haddr_out, a);
         chk("addr.hwrite", 32'(bus.ahb_hwrite_out), 32'(is_wr));
         chk("addr.hsize",  32'(bus.ahb_hsize_out), 32'(sz));
         chk("addr.stall",  32'(stall), 32'd1);
         chk("addr.pulse",  32'({done, err}), 32'd0);
         next_cycle();
      end

      for (int j = 0; j < nd; j++) begin
         bus.ahb_hresp_in  = (err_at >= 0) && (j == err_at);
         bus.ahb_hready_in = bus.ahb_hresp_in ? 1'($urandom) : (!end_err && j == nd - 1);
         bus.ahb_hrdata_in = (!end_err && j == nd - 1) ? rdv : $urandom;
         if (!end_err && j == nd - 1 && !is_wr) cap = rdv;
         @(negedge clk);
         chk("data.htrans", 32'(bus.ahb_htrans_out), 32'd0);
         chk("data.hwdata", bus.ahb_hwdata_out, is_wr ? wd : 32'd0);
         chk("data.wstrb",  32'(bus.ahb_wstrb_out), is_wr ? 32'(m) : 32'd0);
         chk("data.stall",  32'(stall), 32'd1);
         chk("data.pulse",  32'({done, err}), 32'd0);
         next_cycle();
      end

      wr_req = 1'b0; rd_req = 1'b0;
      bus.ahb_hready_in = 1'($urandom);
      bus.ahb_hresp_in  = 1'b0;
      bus.ahb_hrdata_in = $urandom;
      exp_rdata = cap;
      @(negedge clk);
      chk("end.done",   32'(done), 32'(!end_err));
      chk("end.err",    32'(err),  32'(end_err));
      chk("end.tmo",    32'(tmo),  32'(end_tmo));
      chk("end.stall",  32'(stall), 32'd0);
      chk("end.htrans", 32'(bus.ahb_htrans_out), 32'd0);
      chk("end.rdata",  rdata, exp_rdata);
      next_cycle();
      idle_cycle();
   endtask

   initial begin
      int mode, wa, wdw, ea;
      bit w, r;
      rst = 1'b1;
      wr_req = 1'b0; rd_req = 1'b0;
      d_addr = '0; wdata = '0; wr_mask = '0; funct3 = '0;
      bus.ahb_hready_in = 1'b1;
      bus.ahb_hresp_in  = 1'b0;
      bus.ahb_hrdata_in = '0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk_all_zero("reset");
      next_cycle();
      rst = 1'b0;

      run_txn(1, 0, 32'h100, 32'h0000AB00, 4'b0010, 2'b00, 0, 0, -1, 32'h0);
      run_txn(0, 1, 32'h200, 32'h0, 4'h0, 2'b10, 0, 3, -1, 32'hDEADBEEF);
      run_txn(0, 1, 32'h300, 32'h0, 4'h0, 2'b10, 0, 2, 0, 32'h0);
      run_txn(1, 0, 32'h400, 32'h12345678, 4'hF, 2'b10, TO, 0, -1, 32'h0);
      run_txn(0, 1, 32'h404, 32'h0, 4'h0, 2'b01, 0, 0, -1, 32'hCAFEF00D);
      run_txn(1, 0, 32'h408, 32'h0, 4'h0, 2'b10, 0, TO, -1, 32'h0);
      run_txn(1, 1, 32'h500, 32'hA5A5A5A5, 4'hF, 2'b10, 1, 1, -1, 32'h11111111);
      idle_cycle();

      // Reset while the data phase is waiting
      wr_req = 1'b0; rd_req = 1'b1; d_addr = 32'h600; funct3 = 2'b10;
      bus.ahb_hready_in = 1'b1; bus.ahb_hresp_in = 1'b0;
      next_cycle();
      next_cycle();
      bus.ahb_hready_in = 1'b0;
      next_cycle();
      rd_req = 1'b0;
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      exp_rdata = 32'd0;
      @(negedge clk);
      chk_all_zero("mid_rst");
      next_cycle();
      idle_cycle();
      run_txn(0, 1, 32'h604, 32'h0, 4'h0, 2'b10, 0, 0, -1, 32'h87654321);

      for (int t = 0; t < 60; t++) begin
         mode = $urandom_range(0, 7);
         w    = 1'($urandom);
         r    = w ? 1'($urandom) : 1'b1;
         wa   = $urandom_range(0, 4);
         wdw  = $urandom_range(0, 4);
         ea   = -1;
         if (mode == 0) wa = TO + $urandom_range(0, 2);
         else if (mode == 1) wdw = TO;
         else if (mode == 2) ea = $urandom_range(0, wdw);
         run_txn(w, r, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                 2'($urandom), wa, wdw, ea, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
